writeback_stage: RTL

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// writeback_stage
//
// Final pipeline stage.  A stage register captures the memory-stage bundle,
// drives the register-file write port and a registered output port, and
// reassembles two consecutive popped 16-bit stack words into a 32-bit
// return target for RET / RTI.
//
// Ports
//   clk           sole clock, rising edge
//   rst           asynchronous, active-low reset
//   stall         hold stage register, FSM state and out_port
//   flush         load a bubble into the stage register, abort a pending return
//   mem_data      memory-stage read data (also the popped stack word)
//   alu_result    ALU result forwarded through the memory stage
//   rdst          destination register index
//   reg_write     register-file write request
//   mem_to_reg    select mem_data (1) or alu_result (0) for writeback
//   out_port_en   copy the writeback value to out_port
//   ret_pop       mem_data is a popped RET return-address word
//   rti_pop       mem_data is a popped RTI return-address word
//   wb_en         register-file write enable
//   wb_addr       register-file write address
//   wb_data       register-file write data
//   out_port      registered output port
//   pc_load       one-cycle redirect strobe towards fetch
//   pc_target     32-bit return target, held between redirects
//   flag_restore  redirect comes from an RTI, restore flags
//
// Build option
//   WB_FORWARD_EN  when defined, adds fwd_valid / fwd_rdst / fwd_data which
//                  mirror the writeback port for execute-stage forwarding.

module writeback_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] mem_data,
  input  logic [15:0] alu_result,
  input  logic [2:0]  rdst,
  input  logic        reg_write,
  input  logic        mem_to_reg,
  input  logic        out_port_en,
  input  logic        ret_pop,
  input  logic        rti_pop,
  output logic        wb_en,
  output logic [2:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic [15:0] out_port,
  output logic        pc_load,
  output logic [31:0] pc_target,
`ifdef WB_FORWARD_EN
  output logic        flag_restore,
  output logic        fwd_valid,
  output logic [2:0]  fwd_rdst,
  output logic [15:0] fwd_data
`else
  output logic        flag_restore
`endif
);

  typedef struct packed {
    logic [15:0] mem_data;
    logic [15:0] alu_result;
    logic [2:0]  rdst;
    logic        reg_write;
    logic        mem_to_reg;
    logic        out_port_en;
    logic        ret_pop;
    logic        rti_pop;
  } stage_t;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } ret_state_t;

  // A bubble clears every field so nothing stale leaks onto the write port.
  localparam stage_t BUBBLE = stage_t'({$bits(stage_t){1'b0}});

  stage_t      stage_r;
  stage_t      stage_next_s;
  ret_state_t  state_r;
  ret_state_t  state_next_s;
  logic [15:0] hi_r;
  logic [15:0] hi_next_s;
  logic        kind_rti_r;
  logic        kind_rti_next_s;
  logic [31:0] pc_target_r;
  logic [31:0] pc_target_s;
  logic [15:0] out_port_r;
  logic        pop_s;
  logic        pc_load_s;
  logic [15:0] wb_data_s;

  // Stage register next value: flush beats stall, stall holds.
  always_comb begin
    stage_next_s = stage_r;
    if (flush) begin
      stage_next_s = BUBBLE;
    end else if (stall) begin
      stage_next_s = stage_r;
    end else begin
      stage_next_s.mem_data    = mem_data;
      stage_next_s.alu_result  = alu_result;
      stage_next_s.rdst        = rdst;
      stage_next_s.reg_write   = reg_write;
      stage_next_s.mem_to_reg  = mem_to_reg;
      stage_next_s.out_port_en = out_port_en;
      stage_next_s.ret_pop     = ret_pop;
      stage_next_s.rti_pop     = rti_pop;
    end
  end

  // Stage register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_r <= BUBBLE;
    end else begin
      stage_r <= stage_next_s;
    end
  end

  // Writeback datapath from the staged entry; popped words never reach the
  // register file.
  always_comb begin
    pop_s     = stage_r.ret_pop | stage_r.rti_pop;
    wb_data_s = stage_r.mem_to_reg ? stage_r.mem_data : stage_r.alu_result;
  end

  // Return-assembly FSM: first popped word is the high half, the next popped
  // word is the low half.  Non-pop entries in between are simply waited out.
  // The redirect strobe is suppressed while the stage is stalled or flushed,
  // so a held pop entry produces exactly one pulse once the stall drops.
  always_comb begin
    state_next_s    = state_r;
    hi_next_s       = hi_r;
    kind_rti_next_s = kind_rti_r;
    pc_load_s       = 1'b0;
    if (flush) begin
      state_next_s    = IDLE;
      hi_next_s       = 16'h0000;
      kind_rti_next_s = 1'b0;
    end else if (stall) begin
      state_next_s    = state_r;
      hi_next_s       = hi_r;
      kind_rti_next_s = kind_rti_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            state_next_s    = WAIT_LOW;
            hi_next_s       = stage_r.mem_data;
            // RTI wins when both pop kinds are flagged on the same word.
            kind_rti_next_s = stage_r.rti_pop;
          end else begin
            state_next_s = IDLE;
          end
        end
        WAIT_LOW: begin
          if (pop_s) begin
            pc_load_s    = 1'b1;
            state_next_s = IDLE;
          end else begin
            state_next_s = WAIT_LOW;
          end
        end
        default: begin
          state_next_s    = IDLE;
          hi_next_s       = 16'h0000;
          kind_rti_next_s = 1'b0;
        end
      endcase
    end
  end

  // FSM state, latched high word and return kind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      hi_r       <= 16'h0000;
      kind_rti_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      hi_r       <= hi_next_s;
      kind_rti_r <= kind_rti_next_s;
    end
  end

  // The target is visible in the strobe cycle itself and then held.
  always_comb begin
    if (pc_load_s) begin
      pc_target_s = {hi_r, stage_r.mem_data};
    end else begin
      pc_target_s = pc_target_r;
    end
  end

  // Held copy of the last redirect target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_target_r <= 32'h0000_0000;
    end else begin
      pc_target_r <= pc_target_s;
    end
  end

  // Registered output port, frozen under stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_port_r <= 16'h0000;
    end else if (!stall && stage_r.out_port_en) begin
      out_port_r <= wb_data_s;
    end else begin
      out_port_r <= out_port_r;
    end
  end

  assign wb_en        = stage_r.reg_write & ~pop_s;
  assign wb_addr      = stage_r.rdst;
  assign wb_data      = wb_data_s;
  assign out_port     = out_port_r;
  assign pc_load      = pc_load_s;
  assign pc_target    = pc_target_s;
  assign flag_restore = pc_load_s & kind_rti_r;

`ifdef WB_FORWARD_EN
  assign fwd_valid = wb_en;
  assign fwd_rdst  = wb_addr;
  assign fwd_data  = wb_data_s;
`endif

endmodule
